sdram_port_arbiter: RTL
=======================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_REQ, 3, number of requesters (weight fetch, activation fetch, result writeback).
- AW, 24, request address width.
- DW, 16, data width; matches the SDRAM controller user port.
- CMD_HOLD, 2, cycles after the issue cycle until a write is acknowledged (range 1..15).
- RD_LAT, 3, cycles from the issue cycle to the cycle in which mem_data_out is valid (range 1..15).

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, synchronous active-high reset.
- req, in, NUM_REQ, per-requester request level.
- req_we, in, NUM_REQ, 1 = write, 0 = read.
- req_addr, in, NUM_REQ*AW, packed addresses; requester i in slice i.
- req_wdata, in, NUM_REQ*DW, packed write data.
- ack, out, NUM_REQ, one-cycle completion pulse per requester.
- rdata, out, DW, read data; valid when ack is pulsed for a read.
- grant, out, NUM_REQ, one-hot owner of the in-flight transaction.
- busy, out, 1, high whenever the state is not IDLE.
- mem_chip_sel, mem_wr_en, mem_rd_en, out, 1 each, to the controller's chip_sel, wr_en and rd_en.
- mem_addr, out, AW, transaction address.
- mem_data_in, out, DW, to the controller's data_in.
- mem_data_out, in, DW, from the controller's data_out.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-004 In IDLE with any req bit high, the block SHALL pick the winner by round-robin, register its we/addr/wdata, set grant one-hot, and move to ISSUE.
REQ-005 Round-robin search SHALL start at ptr+1 mod NUM_REQ, where ptr is the last granted index; ptr SHALL update on each grant.
REQ-006 ISSUE SHALL last exactly one cycle: mem_chip_sel=1, with mem_wr_en=we or mem_rd_en=!we; the counter loads CMD_HOLD-1 (write) or RD_LAT-1 (read); the FSM moves to WAIT.
REQ-007 WAIT SHALL hold mem_chip_sel=1, mem_wr_en=mem_rd_en=0, and mem_addr/mem_data_in stable, decrementing the counter each cycle.
REQ-008 When the counter reaches 0 in WAIT, the FSM SHALL return to IDLE and the block SHALL register ack[g]=1 for one cycle; for a read, rdata SHALL register mem_data_out in that same cycle.
REQ-009 Latency with the request seen in IDLE at cycle 0: issue at cycle 1; write ack at cycle 1+CMD_HOLD; mem_data_out sampled at cycle 1+RD_LAT; read ack and rdata at cycle 2+RD_LAT.
REQ-010 grant SHALL stay high from ISSUE through the ack cycle and be 0 in IDLE otherwise.
REQ-011 The earliest next issue SHALL be 2 cycles after ack; the FSM does not overlap transactions.
REQ-012 A requester SHALL hold req, req_we, req_addr and req_wdata until ack; a dropped req after grant SHALL NOT abort the transaction, and ack is still pulsed.
REQ-013 A req bit held high through its own ack SHALL be treated as a new request.
REQ-014 Fairness: a continuously asserted req SHALL be granted within NUM_REQ-1 intervening transactions.
REQ-015 rdata SHALL hold its last value until the next read ack.
REQ-016 Write ack SHALL NOT modify rdata.

Reset
REQ-017 reset SHALL force the state to IDLE, ptr to NUM_REQ-1 (so requester 0 wins first), and the counter to 0.
REQ-018 reset SHALL force all outputs (ack, grant, busy, mem_*, rdata) to 0 on the next edge.
REQ-019 A reset during ISSUE or WAIT SHALL abandon the transaction with no ack.

Structure
REQ-020 Package sdram_arb_pkg SHALL hold the state enum and the default values of NUM_REQ, AW, DW, CMD_HOLD and RD_LAT.
REQ-021 The round-robin pick SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs valid and a one-hot/index result), instantiated once.

Verification
REQ-022 Single write, requester 1, addr 0x000010, wdata 0xBEEF at cycle 0 -> mem_wr_en=1 only at cycle 1 with mem_data_in=0xBEEF; ack[1] at cycle 3 only.
REQ-023 Single read, requester 2, with the model driving mem_data_out=0x1234 at cycle 4 -> mem_rd_en=1 at cycle 1; ack[2]=1 and rdata=0x1234 at cycle 5.
REQ-024 req=3'b111 held continuously from reset -> grant order 0,1,2,0,1,2 with no requester acked twice in a row.
REQ-025 Reset asserted at cycle 2 of a read -> no ack; all outputs 0 next cycle; a subsequent request is issued normally.
REQ-026 req[0] dropped one cycle after grant -> transaction completes and ack[0] still pulses; with req[1] also pending, req[1] is granted next.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared state enum and default parameters for the SDRAM port arbiter
package sdram_arb_pkg;

    localparam int DEF_NUM_REQ  = 3;
    localparam int DEF_AW       = 24;
    localparam int DEF_DW       = 16;
    localparam int DEF_CMD_HOLD = 2;
    localparam int DEF_RD_LAT   = 3;

    // Wide enough for CMD_HOLD/RD_LAT up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts one past i_ptr
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic               o_valid,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IW-1:0]      o_idx
);

    logic w_found;

    // Indices above ptr have priority, then wrap around to 0..ptr.
    always_comb begin
        w_found  = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (IW'(i) > i_ptr)) begin
                w_found     = 1'b1;
                o_onehot[i] = 1'b1;
                o_idx       = IW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && (IW'(i) <= i_ptr)) begin
                w_found     = 1'b1;
                o_onehot[i] = 1'b1;
                o_idx       = IW'(i);
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin arbiter sharing one SDRAM controller user port
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int CMD_HOLD = DEF_CMD_HOLD,
    parameter int RD_LAT   = DEF_RD_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    ack,
    output logic [DW-1:0]         rdata,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  busy,
    output logic                  mem_chip_sel,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_data_in,
    input  logic [DW-1:0]         mem_data_out
);

    localparam int                IW      = idx_w(NUM_REQ);
    localparam logic [CNT_W-1:0]  WR_LOAD = CNT_W'(CMD_HOLD - 1);
    localparam logic [CNT_W-1:0]  RD_LOAD = CNT_W'(RD_LAT - 1);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [IW-1:0]       r_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_we;
    logic [AW-1:0]       r_addr;
    logic [DW-1:0]       r_wdata;
    logic [NUM_REQ-1:0]  r_grant;
    logic [NUM_REQ-1:0]  r_ack;
    logic [DW-1:0]       r_rdata;

    logic                w_valid;
    logic [NUM_REQ-1:0]  w_onehot;
    logic [IW-1:0]       w_idx;
    logic                w_arb;
    logic                w_wr_done;
    logic                w_sel_we;
    logic [AW-1:0]       w_sel_addr;
    logic [DW-1:0]       w_sel_wdata;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_onehot (w_onehot),
        .o_idx    (w_idx)
    );

    // No arbitration in the read-ack cycle, which spaces issues two cycles after any ack.
    assign w_arb = (r_state == ST_IDLE) && !(|r_ack) && w_valid;

    // Write ack lands in the last WAIT cycle so it appears CMD_HOLD cycles after issue.
    assign w_wr_done = r_we &&
                       (((r_state == ST_ISSUE) && (CMD_HOLD == 1)) ||
                        ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1))));

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_onehot[i]) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*AW +: AW];
                w_sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_arb) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        mem_chip_sel = 1'b0;
        mem_wr_en    = 1'b0;
        mem_rd_en    = 1'b0;
        case (r_state)
            ST_ISSUE: begin
                busy         = 1'b1;
                mem_chip_sel = 1'b1;
                mem_wr_en    = r_we;
                mem_rd_en    = !r_we;
            end
            ST_WAIT: begin
                busy         = 1'b1;
                mem_chip_sel = 1'b1;
            end
            default: begin
                busy         = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= IW'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_grant <= '0;
            r_ack   <= '0;
            r_rdata <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb) begin
                        r_grant <= w_onehot;
                        r_ptr   <= w_idx;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                    end else begin
                        r_grant <= '0;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= r_we ? WR_LOAD : RD_LOAD;
                end
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (r_we) begin
                        r_grant <= '0;
                    end else begin
                        r_ack   <= r_grant;
                        r_rdata <= mem_data_out;
                    end
                end
                default: begin
                    r_grant <= '0;
                end
            endcase
            if (w_wr_done) begin
                r_ack <= r_grant;
            end
        end
    end

    assign ack         = r_ack;
    assign grant       = r_grant;
    assign rdata       = r_rdata;
    assign mem_addr    = r_addr;
    assign mem_data_in = r_wdata;

endmodule
